// File: rtl/mpx_stereo_decoder_192.sv
// Stereo MPX decoder: coherent 38 kHz demodulation, 4:1 integrate-and-dump to 48 kHz L/R.
// Optional output de-emphasis when MPX_DEC_DEEMPH_EN is defined.
module mpx_stereo_decoder_192 #(
  parameter int unsigned MPX_W     = 24,
  parameter int unsigned OUT_W     = 18,
  parameter int unsigned PHASE_W   = 16,
  parameter int unsigned PHASE_INC = 12971
`ifdef MPX_DEC_DEEMPH_EN
  ,
  parameter int unsigned DEEMPH_SH = 3
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clken_192_i,
  input  logic signed [MPX_W-1:0] mpx_in_i,
  input  logic                    sync_i,
  input  logic                    mono_i,
  output logic signed [OUT_W-1:0] l_out_o,
  output logic signed [OUT_W-1:0] r_out_o,
  output logic                    out_valid_o
);

  localparam int unsigned SUM_W  = MPX_W + 2;
  localparam int unsigned DIFF_W = MPX_W + 10;
  localparam int unsigned PROD_W = MPX_W + 8;
  localparam int unsigned CALC_W = MPX_W + 4;
  localparam int unsigned OUT_SH = 1 + MPX_W - OUT_W;

  localparam logic signed [CALC_W-1:0] SAT_HI = CALC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [CALC_W-1:0] SAT_LO = ~SAT_HI;

  logic        [PHASE_W-1:0] phase_q, phase_d;
  logic        [1:0]         count_q, count_d;
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic signed [DIFF_W-1:0]  diff_q, diff_d;
  logic signed [OUT_W-1:0]   l_q, l_d, r_q, r_d;
  logic                      valid_q, valid_d;

  // First quadrant of round(127*sin(2*pi*k/64)), k = 0..16.
  function automatic logic [6:0] quarter_sine(input logic [4:0] q);
    logic [6:0] m;
    m = 7'd0;
    case (q)
      5'd0:  m = 7'd0;
      5'd1:  m = 7'd12;
      5'd2:  m = 7'd25;
      5'd3:  m = 7'd37;
      5'd4:  m = 7'd49;
      5'd5:  m = 7'd60;
      5'd6:  m = 7'd71;
      5'd7:  m = 7'd81;
      5'd8:  m = 7'd90;
      5'd9:  m = 7'd98;
      5'd10: m = 7'd106;
      5'd11: m = 7'd112;
      5'd12: m = 7'd117;
      5'd13: m = 7'd122;
      5'd14: m = 7'd125;
      5'd15: m = 7'd126;
      5'd16: m = 7'd127;
      default: m = 7'd0;
    endcase
    return m;
  endfunction

  function automatic logic signed [7:0] sine_lut(input logic [5:0] k);
    logic [4:0] q;
    logic [7:0] mag;
    q   = k[4] ? 5'(6'd32 - {1'b0, k[4:0]}) : {1'b0, k[3:0]};
    mag = {1'b0, quarter_sine(q)};
    return k[5] ? 8'(-mag) : mag;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [CALC_W-1:0] v);
    if (v > SAT_HI) return OUT_W'(SAT_HI);
    if (v < SAT_LO) return OUT_W'(SAT_LO);
    return OUT_W'(v);
  endfunction

  // A coincident sync restarts the frame before the sample is taken.
  logic        [PHASE_W-1:0] phase_base_c;
  logic        [1:0]         count_base_c;
  logic signed [SUM_W-1:0]   sum_base_c;
  logic signed [DIFF_W-1:0]  diff_base_c;
  logic signed [7:0]         carrier_c;
  logic signed [PROD_W-1:0]  prod_c;

  assign phase_base_c = sync_i ? '0 : phase_q;
  assign count_base_c = sync_i ? '0 : count_q;
  assign sum_base_c   = sync_i ? '0 : sum_q;
  assign diff_base_c  = sync_i ? '0 : diff_q;
  assign carrier_c    = sine_lut(phase_base_c[PHASE_W-1 -: 6]);
  assign prod_c       = PROD_W'(mpx_in_i) * PROD_W'(carrier_c);

  logic signed [SUM_W-1:0]  sum_tot;
  logic signed [DIFF_W-1:0] diff_tot;
  logic signed [CALC_W-1:0] sum_avg, diff_avg, l_full, r_full;
  logic signed [OUT_W-1:0]  l_sat, r_sat;
`ifdef MPX_DEC_DEEMPH_EN
  logic signed [OUT_W:0]    l_dl, r_dl;
`endif

  // Next-state: accumulate, dump on the fourth sample, sync restart.
  always_comb begin
    phase_d  = phase_base_c;
    count_d  = count_base_c;
    sum_d    = sum_base_c;
    diff_d   = diff_base_c;
    l_d      = l_q;
    r_d      = r_q;
    valid_d  = 1'b0;
    sum_tot  = sum_base_c + SUM_W'(mpx_in_i);
    diff_tot = diff_base_c + DIFF_W'(prod_c);
    sum_avg  = CALC_W'(sum_tot >>> 2);
    diff_avg = CALC_W'(diff_tot >>> 8);
    if (mono_i) begin
      l_full = sum_avg >>> OUT_SH;
      r_full = sum_avg >>> OUT_SH;
    end else begin
      l_full = (sum_avg + diff_avg) >>> OUT_SH;
      r_full = (sum_avg - diff_avg) >>> OUT_SH;
    end
    l_sat = sat(l_full);
    r_sat = sat(r_full);
`ifdef MPX_DEC_DEEMPH_EN
    l_dl = (OUT_W+1)'(l_sat) - (OUT_W+1)'(l_q);
    r_dl = (OUT_W+1)'(r_sat) - (OUT_W+1)'(r_q);
`endif
    if (clken_192_i) begin
      phase_d = phase_base_c + PHASE_W'(PHASE_INC);
      if (count_base_c == 2'd3) begin
        count_d = '0;
        sum_d   = '0;
        diff_d  = '0;
        valid_d = 1'b1;
`ifdef MPX_DEC_DEEMPH_EN
        l_d = OUT_W'((OUT_W+1)'(l_q) + (l_dl >>> DEEMPH_SH));
        r_d = OUT_W'((OUT_W+1)'(r_q) + (r_dl >>> DEEMPH_SH));
`else
        l_d = l_sat;
        r_d = r_sat;
`endif
      end else begin
        count_d = count_base_c + 2'd1;
        sum_d   = sum_tot;
        diff_d  = diff_tot;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      count_q <= '0;
      sum_q   <= '0;
      diff_q  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      diff_q  <= diff_d;
      l_q     <= l_d;
      r_q     <= r_d;
      valid_q <= valid_d;
    end
  end

  assign l_out_o     = l_q;
  assign r_out_o     = r_q;
  assign out_valid_o = valid_q;

endmodule

// File: tb/tb_mpx_stereo_decoder_192.sv
// Directed and model-driven checks for mpx_stereo_decoder_192.
module tb_mpx_stereo_decoder_192;
  localparam int unsigned MPX_W = 24;
  localparam int unsigned OUT_W = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clken = 1'b0;
  logic sync = 1'b0;
  logic mono = 1'b0;
  logic signed [MPX_W-1:0] mpx = '0;
  logic signed [OUT_W-1:0] l_out, r_out;
  logic out_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int yl = 0;
  int yr = 0;

  int sin_tab [64] = '{
      0,   12,   25,   37,   49,   60,   71,   81,   90,   98,  106,  112,  117,  122,  125,  126,
    127,  126,  125,  122,  117,  112,  106,   98,   90,   81,   71,   60,   49,   37,   25,   12,
      0,  -12,  -25,  -37,  -49,  -60,  -71,  -81,  -90,  -98, -106, -112, -117, -122, -125, -126,
   -127, -126, -125, -122, -117, -112, -106,  -98,  -90,  -81,  -71,  -60,  -49,  -37,  -25,  -12};

  always #5 clk = ~clk;

  mpx_stereo_decoder_192 dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clken_192_i (clken),
    .mpx_in_i    (mpx),
    .sync_i      (sync),
    .mono_i      (mono),
    .l_out_o     (l_out),
    .r_out_o     (r_out),
    .out_valid_o (out_valid)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ck, input logic sy, input int x);
    clken = ck;
    sync  = sy;
    mpx   = MPX_W'(x);
    @(posedge clk);
    #1;
    clken = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic upd_y(input int xl, input int xr);
`ifdef MPX_DEC_DEEMPH_EN
    yl = yl + ((xl - yl) >>> 3);
    yr = yr + ((xr - yr) >>> 3);
`else
    yl = xl;
    yr = xr;
`endif
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_L"}, 32'(l_out), yl);
    check({tag, "_R"}, 32'(r_out), yr);
  endtask

  task automatic check_dump(input string tag, input int xl, input int xr);
    upd_y(xl, xr);
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_L"}, 32'(l_out), yl);
    check({tag, "_R"}, 32'(r_out), yr);
  endtask

  function automatic longint clamp(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  int     m_ph, m_cnt, xi;
  longint m_s, m_d, xv, sa, da, lv, rv;
  logic   ck, sy, ev;

  initial begin
    // Reset held with random activity on the inputs
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mono = 1'($urandom);
      step(1'($urandom), 1'($urandom), int'($urandom));
      check("rst_valid", 32'(out_valid), 0);
      check("rst_L", 32'(l_out), 0);
      check("rst_R", 32'(r_out), 0);
    end
    rst_n = 1'b1;
    mono  = 1'b0;
    step(0, 0, 0);

    // Mono frame with idle gaps between strobes
    mono = 1'b1;
    step(0, 1, 0);
    check_hold("mono_sync");
    step(1, 0, 64000); check_hold("mono_s0");
    step(0, 0, 0);
    step(1, 0, 64000); check_hold("mono_s1");
    step(0, 0, 0);
    step(1, 0, 64000); check_hold("mono_s2");
    step(1, 0, 64000); check_dump("mono", 500, 500);
    step(0, 0, 0);     check_hold("mono_hold");

    // Stereo frame, back-to-back strobes; mono only matters at the dump
    step(0, 1, 0);
    mono = 1'b1;
    step(1, 0, 64000); check_hold("st_s0");
    step(1, 0, 64000); check_hold("st_s1");
    step(1, 0, 64000); check_hold("st_s2");
    mono = 1'b0;
    step(1, 0, 64000); check_dump("stereo", 748, 251);
    step(0, 0, 0);     check_hold("st_hold");

    // Sync coincident with a strobe mid-frame restarts at sample 0
    step(0, 1, 0);
    step(1, 0, 12345); check_hold("sm_a0");
    step(1, 0, -9999); check_hold("sm_a1");
    step(1, 1, 64000); check_hold("sm_s0");
    step(1, 0, 64000); check_hold("sm_s1");
    step(1, 0, 64000); check_hold("sm_s2");
    step(1, 0, 64000); check_dump("sync_mid", 748, 251);

    // Reset mid-frame discards the partial frame
    step(0, 1, 0);
    step(1, 0, 777);
    step(1, 0, 777);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    yl = 0;
    yr = 0;
    check_hold("rm_rst");
    rst_n = 1'b1;
    mono  = 1'b1;
    step(1, 0, 64000); check_hold("rm_s0");
    step(1, 0, 64000); check_hold("rm_s1");
    step(1, 0, 64000); check_hold("rm_s2");
    step(1, 0, 64000); check_dump("rst_mid", 500, 500);

    // Random strobes against a reference model
    step(0, 1, 0);
    m_ph = 0; m_cnt = 0; m_s = 0; m_d = 0;
    for (int i = 0; i < 1200; i++) begin
      ck   = ($urandom % 3) != 0;
      sy   = ($urandom % 61) == 0;
      mono = 1'($urandom);
      xi   = int'($urandom);
      mpx  = MPX_W'(xi);
      xv   = longint'(mpx);
      ev   = 1'b0;
      if (sy) begin
        m_ph = 0; m_cnt = 0; m_s = 0; m_d = 0;
      end
      if (ck) begin
        m_s = m_s + xv;
        m_d = m_d + xv * longint'(sin_tab[m_ph >> 10]);
        if (m_cnt == 3) begin
          sa = m_s >>> 2;
          da = m_d >>> 8;
          lv = mono ? (sa >>> 7) : ((sa + da) >>> 7);
          rv = mono ? (sa >>> 7) : ((sa - da) >>> 7);
          upd_y(int'(clamp(lv)), int'(clamp(rv)));
          ev = 1'b1;
          m_cnt = 0; m_s = 0; m_d = 0;
        end else begin
          m_cnt++;
        end
        m_ph = (m_ph + 12971) & 65535;
      end
      step(ck, sy, xi);
      check("rnd_valid", 32'(out_valid), 32'(ev));
      check("rnd_L", 32'(l_out), yl);
      check("rnd_R", 32'(r_out), yr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
